ifu_fetch_queue: RTL

//  Producer end of the decode interface: generates sequential fetch PCs, issues in-order requests to

---
 rtl/ifu_pkg.sv | 20 ++
 rtl/ifu_fetch_queue_if.sv | 27 ++
 rtl/ifu_sync_fifo.sv | 60 ++++++
 rtl/ifu_fetch_queue.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit.
//   fetch_state_e : fetch FSM states
//   fq_entry_t    : one fetch-queue entry {inst, pc}
package ifu_pkg;

    localparam int unsigned INST_WIDTH = 32;
    localparam int unsigned PC_WIDTH   = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [PC_WIDTH-1:0]   pc;
    } fq_entry_t;

endpackage

// File: rtl/ifu_fetch_queue_if.sv
// Fetch queue bus: imem request/response channel plus decode-side queue head.
//   master : the fetch queue (drives requests and the queue head)
//   slave  : the environment (memory + decode)
interface ifu_fetch_queue_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    logic                      imem_req_valid;
    logic                      imem_req_ready;
    logic [31:0]               imem_req_addr;
    logic                      imem_resp_valid;
    logic [31:0]               imem_resp_data;
    logic                      fq_valid;
    logic                      fq_ready;
    logic [31:0]               fq_inst;
    logic [31:0]               fq_pc;
    logic [$clog2(FIFO_DEPTH):0] fq_count;

    modport master (
        output imem_req_valid, imem_req_addr, fq_valid, fq_inst, fq_pc, fq_count,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, fq_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, fq_valid, fq_inst, fq_pc, fq_count,
        output imem_req_ready, imem_resp_valid, imem_resp_data, fq_ready
    );
endinterface

// File: rtl/ifu_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; storage is reset so the
// head reads as zero when empty after reset.
//   i_flush : drop all entries (wins over push/pop)
//   i_push/i_data, i_pop : write / consume head
//   o_data  : head entry, o_empty, o_count : occupancy
module ifu_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;

    // Pointer, count and storage update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= r_wp + AW'(1);
            end
            if (i_pop) r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_data  = r_mem[r_rp];
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;

    // Callers guarantee credit; overflow/underflow would be a design bug
    always @(posedge clk) begin
        if (rst_n && !i_flush) begin
            assert (!(i_push && (r_cnt == CW'(DEPTH)) && !i_pop));
            assert (!(i_pop && (r_cnt == '0)));
        end
    end
endmodule

// File: rtl/ifu_fetch_queue.sv
// Fetch queue: sequential PC generation, credit-limited in-order imem
// requests, response buffering and redirect flush with stale-response drop.
//   clk, rst_n               : clock, async active-low reset
//   fetch_en                 : allow new requests
//   redirect_valid/_pc       : flush and restart fetch
//   bus (master)             : imem request/response and decode queue head
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h1c00_0000,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned MAX_OUTSTAND = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_en,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    ifu_fetch_queue_if.master   bus
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OST_W = $clog2(MAX_OUTSTAND) + 1;
    localparam int unsigned SUM_W = ((CNT_W > OST_W) ? CNT_W : OST_W) + 1;

    fetch_state_e        r_state;
    fetch_state_e        w_state_next;
    logic                w_run;
    logic [PC_WIDTH-1:0] r_pc;
    logic [OST_W-1:0]    r_outstand;
    logic [OST_W-1:0]    r_drop;
    logic [OST_W-1:0]    w_outstand_next;
    logic [OST_W-1:0]    w_drop_next;
    logic                w_req_valid;
    logic                w_accept;
    logic                w_resp;
    logic                w_dropping;
    logic                w_push;
    logic                w_pop;
    logic                w_fq_empty;
    logic [CNT_W-1:0]    w_fq_count;
    logic [PC_WIDTH-1:0] w_tag_pc;
    logic                w_tag_empty;
    logic [OST_W-1:0]    w_tag_count;
    fq_entry_t           w_push_entry;
    fq_entry_t           w_head;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // FSM next state; redirects never change state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (fetch_en)  w_state_next = S_RUN;
            S_RUN:   if (!fetch_en) w_state_next = S_HALT;
            S_HALT:  if (fetch_en)  w_state_next = S_RUN;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_run = 1'b0;
        if (r_state == S_RUN) w_run = 1'b1;
    end

    // Credit: every in-flight request already owns a queue slot
    assign w_req_valid = w_run && !redirect_valid
                      && ((SUM_W'(r_outstand) + SUM_W'(w_fq_count)) < SUM_W'(FIFO_DEPTH))
                      && (r_outstand < OST_W'(MAX_OUTSTAND));
    assign w_accept        = w_req_valid && bus.imem_req_ready;
    assign w_resp          = bus.imem_resp_valid;
    assign w_dropping      = (r_drop != '0);
    assign w_outstand_next = r_outstand + OST_W'(w_accept) - OST_W'(w_resp);
    assign w_push          = w_resp && !w_dropping && !redirect_valid;
    assign w_pop           = !w_fq_empty && bus.fq_ready;
    assign w_push_entry    = '{inst: bus.imem_resp_data, pc: w_tag_pc};

    // On redirect everything still in flight (after this cycle) is stale
    always_comb begin
        w_drop_next = r_drop;
        if (redirect_valid)            w_drop_next = w_outstand_next;
        else if (w_resp && w_dropping) w_drop_next = r_drop - OST_W'(1);
    end

    // PC, in-flight and drop counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_outstand <= '0;
            r_drop     <= '0;
        end else begin
            r_outstand <= w_outstand_next;
            r_drop     <= w_drop_next;
            if (redirect_valid) r_pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
            else if (w_accept)  r_pc <= r_pc + 32'd4;
        end
    end

    // PC tags of in-flight requests; never flushed, every response pops one
    ifu_sync_fifo #(.WIDTH(PC_WIDTH), .DEPTH(MAX_OUTSTAND)) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (1'b0),
        .i_push  (w_accept),
        .i_data  (r_pc),
        .i_pop   (w_resp),
        .o_data  (w_tag_pc),
        .o_empty (w_tag_empty),
        .o_count (w_tag_count)
    );

    // Instruction queue toward decode
    ifu_sync_fifo #(.WIDTH($bits(fq_entry_t)), .DEPTH(FIFO_DEPTH)) u_inst_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_fq_empty),
        .o_count (w_fq_count)
    );

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.fq_valid       = !w_fq_empty;
    assign bus.fq_inst        = w_head.inst;
    assign bus.fq_pc          = w_head.pc;
    assign bus.fq_count       = w_fq_count;

    // Tag queue must track the in-flight counter exactly
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(w_resp && w_tag_empty));
            assert (w_tag_count == r_outstand);
        end
    end
endmodule
